// File: rtl/lnvd_gpio_frame_rx.sv
// Receive end of the LNVD 4-channel parallel link: synchronizes the frame strobe,
// captures one 32-bit frame per strobe rising edge into a FWFT FIFO, and reports status.
module lnvd_gpio_frame_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 4096,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   gpio_data,
  input  logic                          gpio_strobe,
  output logic [7:0]                    out_ch1,
  output logic [7:0]                    out_ch2,
  output logic [7:0]                    out_ch3,
  output logic [7:0]                    out_ch4,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          clear_ovf,
  output logic                          overflow,
  output logic [CNT_W-1:0]              frame_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          link_up
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          s1, s2, s3;
  logic [2:0]    prime;
  logic [31:0]   d1, d2;
  logic          rise, full, push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0] idle_cnt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   head;

  // prime marks when s3 holds a genuine post-reset sample, so a strobe already
  // high at reset release is not mistaken for a fresh rising edge.
  assign rise = s2 & ~s3 & prime[2];

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign push      = rise & (~full | pop);

  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign out_ch1 = head[7:0];
  assign out_ch2 = head[15:8];
  assign out_ch3 = head[23:16];
  assign out_ch4 = head[31:24];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      prime <= '0;
      d1    <= '0;
      d2    <= '0;
    end else begin
      s1    <= gpio_strobe;
      s2    <= s1;
      s3    <= s2;
      prime <= {prime[1:0], 1'b1};
      d1    <= gpio_data;
      d2    <= d1;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by fifo_level and
  // the head is forced to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      frame_count <= '0;
    end else begin
      if (rise & full & ~pop) overflow <= 1'b1;
      else if (clear_ovf)     overflow <= 1'b0;
      if (rise) frame_count <= frame_count + CNT_W'(1);
    end
  end

  // link_up falls on the same edge the idle counter reaches TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      link_up  <= 1'b0;
    end else if (rise) begin
      idle_cnt <= '0;
      link_up  <= 1'b1;
    end else if (idle_cnt != TW'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + TW'(1);
      if (idle_cnt == TW'(TIMEOUT - 1)) link_up <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lnvd_gpio_frame_rx.sv
// Directed, scoreboard-based bench for lnvd_gpio_frame_rx (FIFO_DEPTH=8, TIMEOUT=16).
module tb_lnvd_gpio_frame_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   gpio_data;
  logic          gpio_strobe;
  logic [7:0]    out_ch1, out_ch2, out_ch3, out_ch4;
  logic          out_valid;
  logic          out_ready;
  logic          clear_ovf;
  logic          overflow;
  logic [CW-1:0] frame_count;
  logic [3:0]    fifo_level;
  logic          link_up;

  int tests = 0;
  int fails = 0;
  int n_frames = 0;
  int max_lvl = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  lnvd_gpio_frame_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .gpio_data(gpio_data), .gpio_strobe(gpio_strobe),
    .out_ch1(out_ch1), .out_ch2(out_ch2), .out_ch3(out_ch3), .out_ch4(out_ch4),
    .out_valid(out_valid), .out_ready(out_ready), .clear_ovf(clear_ovf),
    .overflow(overflow), .frame_count(frame_count), .fifo_level(fifo_level),
    .link_up(link_up)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set: checks a pop due at the next
  // posedge against the scoreboard, then advances one clock.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_pop", {out_ch4, out_ch3, out_ch2, out_ch1}, 32'hDEAD_BEEF);
        else chk("sb_pop_data", {out_ch4, out_ch3, out_ch2, out_ch1}, sb.pop_front());
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [31:0] data, input bit keep);
    gpio_data = data;
    cyc(2);
    gpio_strobe = 1'b1;
    n_frames++;
    if (keep) sb.push_back(data);
    cyc(3);
    gpio_strobe = 1'b0;
    cyc(2);
  endtask

  initial begin
    reset_n = 1'b0; gpio_data = '0; gpio_strobe = 1'b0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cyc(4);

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", {out_ch4, out_ch3, out_ch2, out_ch1}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_link", link_up, 0);

    // Single frame, first-word fall-through within 3 clocks of the strobe
    gpio_data = 32'hA1B2C3D4;
    cyc(2);
    gpio_strobe = 1'b1; n_frames++; sb.push_back(32'hA1B2C3D4);
    cyc(3);
    gpio_strobe = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_ch1", out_ch1, 8'hD4);
    chk("single_ch2", out_ch2, 8'hC3);
    chk("single_ch3", out_ch3, 8'hB2);
    chk("single_ch4", out_ch4, 8'hA1);
    chk("single_count", frame_count, 1);
    chk("single_link", link_up, 1);
    chk("single_level", fifo_level, 1);
    cyc(3);
    chk("single_hold", {out_ch4, out_ch3, out_ch2, out_ch1}, 32'hA1B2C3D4);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("single_drained", fifo_level, 0);

    // Timeout: link_up high for 16 edges after the capture edge, then low
    out_ready = 1'b1;
    gpio_data = 32'h0F0E0D0C;
    cyc(20);
    gpio_strobe = 1'b1; n_frames++; sb.push_back(32'h0F0E0D0C);
    cyc(3);
    gpio_strobe = 1'b0;
    chk("tmo_link_k0", link_up, 1);
    cyc(15);
    chk("tmo_link_k15", link_up, 1);
    cyc(1);
    chk("tmo_link_k16", link_up, 0);
    cyc(5);
    chk("tmo_link_idle", link_up, 0);
    send(32'h11223344, 1'b1);
    chk("tmo_link_back", link_up, 1);
    cyc(3);

    // Throughput / order with out_ready held high, strobe period 10
    max_lvl = 0;
    for (int k = 0; k < 8; k++) begin
      send({4{k[7:0]}}, 1'b1);
      cyc(3);
    end
    chk("tp_max_level", max_lvl, 1);
    chk("tp_sb_empty", sb.size(), 0);
    chk("tp_ovf", overflow, 0);
    out_ready = 1'b0;

    // Overflow: 10 frames into an 8-deep FIFO, last two dropped
    for (int k = 1; k <= 10; k++) send({4{k[7:0]}}, k <= DEPTH);
    chk("ovf_level", fifo_level, DEPTH);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", frame_count, n_frames);
    out_ready = 1'b1;
    cyc(DEPTH);
    out_ready = 1'b0;
    chk("ovf_drain_level", fifo_level, 0);
    chk("ovf_drain_sb", sb.size(), 0);
    chk("ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    cyc(1);
    clear_ovf = 1'b0;
    chk("ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the exact write cycle
    for (int k = 1; k <= DEPTH; k++) send(32'h2000_0000 | k, 1'b1);
    chk("fp_full", fifo_level, DEPTH);
    gpio_data = 32'h55AA55AA;
    cyc(2);
    gpio_strobe = 1'b1; n_frames++; sb.push_back(32'h55AA55AA);
    cyc(2);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    gpio_strobe = 1'b0;
    cyc(2);
    chk("fp_level", fifo_level, DEPTH);
    chk("fp_ovf", overflow, 0);
    out_ready = 1'b1;
    cyc(DEPTH);
    out_ready = 1'b0;
    chk("fp_sb_empty", sb.size(), 0);

    // Reset mid-stream with the strobe held high across release
    for (int k = 0; k < 3; k++) send(32'hC0DE_0000 | k, 1'b1);
    chk("mr_level", fifo_level, 3);
    gpio_strobe = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    sb.delete();
    n_frames = 0;
    #1;
    chk("mr_valid_now", out_valid, 0);
    chk("mr_count_now", frame_count, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    cyc(8);
    chk("mr_no_capture_cnt", frame_count, 0);
    chk("mr_no_capture_vld", out_valid, 0);
    gpio_strobe = 1'b0;
    cyc(3);
    chk("mr_still_none", frame_count, 0);
    send(32'h0BADCAFE, 1'b1);
    chk("mr_fresh_count", frame_count, 1);
    chk("mr_fresh_valid", out_valid, 1);
    out_ready = 1'b1;
    cyc(2);
    out_ready = 1'b0;
    chk("mr_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
